// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for a single-ported memory
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  // Parameter sanity: empty blocks only exist to make bad settings visible in elaboration.
  if (MEM_LATENCY < 1) begin : g_mem_latency_invalid
  end
  if (STARVE_MAX < 1) begin : g_starve_max_invalid
  end

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            win_ls;
  logic            lat_we;
  logic            pick_if;
  logic            pick_ls;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    pick_if = if_req && (!ls_req || starved);
    pick_ls = ls_req && !pick_if;
  end

  // Counts back-to-back load/store wins that left fetch waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!if_req || pick_if) begin
        starve_cnt <= '0;
      end else if (pick_ls && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  always_comb begin
    pick_if = if_req && !ls_req;
    pick_ls = ls_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (pick_if || pick_ls) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = mem_en && lat_we;
  assign if_gnt    = mem_en && !win_ls;
  assign ls_gnt    = mem_en && win_ls;
  assign if_rvalid = (state == S_RESP) && !win_ls;
  assign ls_rvalid = (state == S_RESP) && win_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      win_ls    <= 1'b0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (pick_ls) begin
            win_ls    <= 1'b1;
            lat_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
          end else if (pick_if) begin
            win_ls   <= 1'b0;
            lat_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        S_ISSUE: wait_cnt <= CW'(MEM_LATENCY - 1);
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (win_ls) begin
            ls_rdata <= lat_we ? '0 : mem_rdata;
          end else begin
            if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata1;
  logic [31:0] mem_rdata3;

  logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3;

  int checks;
  int failures;

  mem_port_arbiter #(.WIDTH(32), .MEM_LATENCY(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.WIDTH(32), .MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The two grant strobes of one arbiter must never fire together.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_exclusive_lat1", {31'd0, if_gnt1 & ls_gnt1}, 32'd0);
      check("gnt_exclusive_lat3", {31'd0, if_gnt3 & ls_gnt3}, 32'd0);
    end
  end

  initial begin
    int busy_cnt;
    int rv_cnt;
    int n;
    logic [9:0] gf;
    logic       exp_f;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = 32'h0;
    ls_wdata   = 32'h0;
    mem_rdata1 = 32'h0;
    mem_rdata3 = 32'h0;

    // Reset held two cycles
    tick();
    tick();
    check("rst_if_gnt",    {31'd0, if_gnt1},    32'd0);
    check("rst_if_rvalid", {31'd0, if_rvalid1}, 32'd0);
    check("rst_if_rdata",  if_rdata1,           32'd0);
    check("rst_ls_gnt",    {31'd0, ls_gnt1},    32'd0);
    check("rst_ls_rvalid", {31'd0, ls_rvalid1}, 32'd0);
    check("rst_ls_rdata",  ls_rdata1,           32'd0);
    check("rst_mem_en",    {31'd0, mem_en1},    32'd0);
    check("rst_mem_we",    {31'd0, mem_we1},    32'd0);
    check("rst_mem_addr",  mem_addr1,           32'd0);
    check("rst_mem_wdata", mem_wdata1,          32'd0);
    check("rst_busy",      {31'd0, busy1},      32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy1}, 32'd0);

    // Single fetch, latency 1
    if_req     = 1'b1;
    if_addr    = 32'h100;
    mem_rdata1 = 32'hDEADBEEF;
    tick();
    check("f_if_gnt",   {31'd0, if_gnt1}, 32'd1);
    check("f_mem_en",   {31'd0, mem_en1}, 32'd1);
    check("f_mem_we",   {31'd0, mem_we1}, 32'd0);
    check("f_mem_addr", mem_addr1,        32'h100);
    check("f_busy",     {31'd0, busy1},   32'd1);
    if_req = 1'b0;
    tick();
    check("f_wait_rvalid", {31'd0, if_rvalid1}, 32'd0);
    check("f_wait_mem_en", {31'd0, mem_en1},    32'd0);
    tick();
    check("f_if_rvalid", {31'd0, if_rvalid1}, 32'd1);
    check("f_if_rdata",  if_rdata1,           32'hDEADBEEF);
    check("f_ls_rvalid", {31'd0, ls_rvalid1}, 32'd0);
    tick();
    check("f_done_rvalid", {31'd0, if_rvalid1}, 32'd0);
    check("f_hold_rdata",  if_rdata1,           32'hDEADBEEF);
    check("f_done_busy",   {31'd0, busy1},      32'd0);

    // Store
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h40;
    ls_wdata = 32'h12345678;
    tick();
    check("s_ls_gnt",    {31'd0, ls_gnt1}, 32'd1);
    check("s_if_gnt",    {31'd0, if_gnt1}, 32'd0);
    check("s_mem_en",    {31'd0, mem_en1}, 32'd1);
    check("s_mem_we",    {31'd0, mem_we1}, 32'd1);
    check("s_mem_addr",  mem_addr1,        32'h40);
    check("s_mem_wdata", mem_wdata1,       32'h12345678);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    tick();
    tick();
    check("s_ls_rvalid", {31'd0, ls_rvalid1}, 32'd1);
    check("s_ls_rdata",  ls_rdata1,           32'd0);
    tick();
    check("s_hold_wdata", mem_wdata1, 32'h12345678);

    // Fetch and load together: load first
    if_req     = 1'b1;
    if_addr    = 32'h200;
    ls_req     = 1'b1;
    ls_addr    = 32'h80;
    mem_rdata1 = 32'hCAFEF00D;
    tick();
    check("b_ls_gnt",   {31'd0, ls_gnt1}, 32'd1);
    check("b_if_gnt",   {31'd0, if_gnt1}, 32'd0);
    check("b_mem_addr", mem_addr1,        32'h80);
    ls_req = 1'b0;
    tick();
    tick();
    check("b_ls_rvalid", {31'd0, ls_rvalid1}, 32'd1);
    check("b_ls_rdata",  ls_rdata1,           32'hCAFEF00D);
    mem_rdata1 = 32'h0F0F1234;
    tick();
    check("b_idle_if_gnt", {31'd0, if_gnt1}, 32'd0);
    check("b_idle_busy",   {31'd0, busy1},   32'd0);
    tick();
    check("b_if_gnt2",  {31'd0, if_gnt1}, 32'd1);
    check("b_mem_addr2", mem_addr1,       32'h200);
    if_req = 1'b0;
    tick();
    tick();
    check("b_if_rvalid", {31'd0, if_rvalid1}, 32'd1);
    check("b_if_rdata",  if_rdata1,           32'h0F0F1234);
    check("b_ls_rdata_hold", ls_rdata1,       32'hCAFEF00D);
    tick();

    // Latency 3 load on second instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ls_req     = 1'b1;
    ls_we      = 1'b0;
    ls_addr    = 32'h44;
    mem_rdata3 = 32'h5555AAAA;
    busy_cnt   = 0;
    tick();
    check("l3_ls_gnt",   {31'd0, ls_gnt3}, 32'd1);
    check("l3_mem_addr", mem_addr3,        32'h44);
    busy_cnt += int'(busy3);
    ls_req = 1'b0;
    tick();
    busy_cnt += int'(busy3);
    tick();
    busy_cnt += int'(busy3);
    check("l3_early_rvalid_a", {31'd0, ls_rvalid3}, 32'd0);
    tick();
    busy_cnt += int'(busy3);
    check("l3_early_rvalid_b", {31'd0, ls_rvalid3}, 32'd0);
    mem_rdata3 = 32'h0BADF00D;
    tick();
    busy_cnt += int'(busy3);
    mem_rdata3 = 32'h5555AAAA;
    check("l3_ls_rvalid", {31'd0, ls_rvalid3}, 32'd1);
    check("l3_ls_rdata",  ls_rdata3,           32'h0BADF00D);
    tick();
    busy_cnt += int'(busy3);
    check("l3_rvalid_off", {31'd0, ls_rvalid3}, 32'd0);
    check("l3_busy_cycles", busy_cnt, 32'd5);

    // Reset during WAIT abandons the access
    if_req  = 1'b1;
    if_addr = 32'h120;
    tick();
    check("rw_if_gnt", {31'd0, if_gnt3}, 32'd1);
    if_req = 1'b0;
    tick();
    check("rw_in_wait_busy", {31'd0, busy3}, 32'd1);
    rst = 1'b1;
    tick();
    check("rw_mem_en", {31'd0, mem_en3}, 32'd0);
    check("rw_busy",   {31'd0, busy3},   32'd0);
    rst    = 1'b0;
    rv_cnt = int'(if_rvalid3);
    for (int i = 0; i < 6; i++) begin
      tick();
      rv_cnt += int'(if_rvalid3) + int'(mem_en3);
    end
    check("rw_no_rvalid", rv_cnt, 32'd0);

    // Both requesters held high: grant pattern
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h300;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h90;
    n       = 0;
    gf      = '0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      tick();
      if (if_gnt1) begin
        gf[n] = 1'b1;
        n++;
      end else if (ls_gnt1) begin
        gf[n] = 1'b0;
        n++;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    check("st_grant_count", n, 32'd10);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_f = ((i % 5) == 4);
`else
      exp_f = 1'b0;
`endif
      check($sformatf("st_grant_%0d_is_fetch", i), {31'd0, gf[i]}, {31'd0, exp_f});
    end

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
